reg_mux_pipe: RTL and testbench



---
 rtl/reg_mux_pipe_pkg.sv | 17 +
 rtl/reg_mux_pipe_if.sv | 25 ++
 rtl/reg_mux_pipe_reg_stage.sv | 23 ++
 rtl/reg_mux_pipe.sv | 77 +++++++
 tb/tb_reg_mux_pipe.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/reg_mux_pipe_pkg.sv
// Shared definitions for the run-time selectable operand delay line.
// Holds default geometry and the latency clamp helper.
package reg_mux_pipe_pkg;

    localparam int unsigned RMP_WIDTH   = 18;
    localparam int unsigned RMP_DEPTH   = 3;
    localparam int unsigned RMP_LAT_W   = 2;
    localparam int unsigned RMP_LAT_RST = 3;

    function automatic int unsigned clamp_lat(
        input int unsigned lat,
        input int unsigned depth
    );
        return (lat > depth) ? depth : lat;
    endfunction

endpackage

// File: rtl/reg_mux_pipe_if.sv
// Operand bus of the delay line: request side and tapped result side.
interface reg_mux_pipe_if
    import reg_mux_pipe_pkg::*;
#(
    parameter int WIDTH = RMP_WIDTH,
    parameter int LAT_W = RMP_LAT_W
);
    logic             ce;
    logic [LAT_W-1:0] lat;
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output ce, lat, in_valid, in,
        input  out, out_valid, busy
    );

    modport slave (
        input  ce, lat, in_valid, in,
        output out, out_valid, busy
    );
endinterface

// File: rtl/reg_mux_pipe_reg_stage.sv
// One delay stage: data plus valid in a single word, with enable and
// synchronous reset.
module reg_mux_pipe_reg_stage #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/reg_mux_pipe.sv
// Delay line of DEPTH stages with run-time latency tap, valid tracking
// and a settle indication after latency changes.
module reg_mux_pipe
    import reg_mux_pipe_pkg::*;
#(
    parameter int WIDTH   = RMP_WIDTH,
    parameter int DEPTH   = RMP_DEPTH,
    parameter int LAT_W   = RMP_LAT_W,
    parameter int LAT_RST = RMP_LAT_RST
) (
    input logic           clk,
    input logic           rst,
    reg_mux_pipe_if.slave bus
);
    logic [LAT_W-1:0] r_lat_q;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_lat_c;
    logic [LAT_W-1:0] w_cnt_ld;
    logic             w_chg;
    logic [WIDTH:0]   w_d [DEPTH];
    logic [WIDTH:0]   w_q [DEPTH];
    logic [WIDTH-1:0] w_out;
    logic             w_out_v;

    assign w_lat_c  = LAT_W'(clamp_lat(32'(bus.lat), DEPTH));
    assign w_chg    = bus.ce && (w_lat_c != r_lat_q);
    assign w_cnt_ld = (w_lat_c == '0) ? '0 : w_lat_c - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_q <= LAT_W'(LAT_RST);
            r_cnt   <= '0;
        end else if (bus.ce) begin
            if (w_chg) begin
                r_lat_q <= w_lat_c;
                r_cnt   <= w_cnt_ld;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // A latency change drops every in-flight valid except the new sample
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_d[g] = {bus.in_valid, bus.in};
        end else begin : g_tail
            assign w_d[g] = {w_q[g-1][WIDTH] & ~w_chg,
                             w_q[g-1][WIDTH-1:0]};
        end

        reg_mux_pipe_reg_stage #(
            .W (WIDTH + 1)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .i_ce (bus.ce),
            .i_d  (w_d[g]),
            .o_q  (w_q[g])
        );
    end

    always_comb begin
        w_out   = bus.in;
        w_out_v = bus.in_valid;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_lat_q == LAT_W'(k + 1)) begin
                w_out   = w_q[k][WIDTH-1:0];
                w_out_v = w_q[k][WIDTH];
            end
        end
    end

    assign bus.out       = w_out;
    assign bus.out_valid = w_out_v;
    assign bus.busy      = (r_cnt != '0);
endmodule

// File: tb/tb_reg_mux_pipe.sv
// Bench for reg_mux_pipe: directed vector table plus random traffic
// against a sample-history reference model.
module tb_reg_mux_pipe;
    localparam int WIDTH   = 18;
    localparam int DEPTH   = 3;
    localparam int LAT_W   = 2;
    localparam int LAT_RST = 3;
    localparam int NVEC    = 26;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_mux_pipe_if #(.WIDTH(WIDTH), .LAT_W(LAT_W)) bus ();

    reg_mux_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .LAT_W   (LAT_W),
        .LAT_RST (LAT_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic             r;
        logic             ce;
        logic [LAT_W-1:0] lat;
        logic             iv;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] eout;
        logic             ev;
        logic             eb;
    } vec_t;

    vec_t vt [NVEC];

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the last DEPTH accepted samples with their sequence
    // numbers; a sample is valid at the tap only if it entered no
    // earlier than the most recent latency change.
    logic [WIDTH-1:0] h_d [DEPTH];
    logic             h_v [DEPTH];
    int               h_i [DEPTH];
    int               m_lat = LAT_RST;
    int               m_chg = 0;
    int               m_age = 1000;
    int               m_n   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        int c;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                h_d[k] = '0;
                h_v[k] = 1'b0;
                h_i[k] = -1;
            end
            m_lat = LAT_RST;
            m_age = 1000;
        end else if (bus.ce) begin
            c = (int'(bus.lat) > DEPTH) ? DEPTH : int'(bus.lat);
            for (int k = DEPTH - 1; k > 0; k--) begin
                h_d[k] = h_d[k-1];
                h_v[k] = h_v[k-1];
                h_i[k] = h_i[k-1];
            end
            h_d[0] = bus.in;
            h_v[0] = bus.in_valid;
            h_i[0] = m_n;
            if (c != m_lat) begin
                m_lat = c;
                m_chg = m_n;
                m_age = 0;
            end else begin
                m_age++;
            end
            m_n++;
        end
    endtask

    task automatic model_check(input string tag);
        logic [WIDTH-1:0] eo;
        logic             ev;
        logic             eb;
        if (m_lat == 0) begin
            eo = bus.in;
            ev = bus.in_valid;
        end else begin
            eo = h_d[m_lat-1];
            ev = h_v[m_lat-1] && (h_i[m_lat-1] >= m_chg);
        end
        eb = (m_lat >= 2) && (m_age < m_lat - 1);
        check({tag, ".out"}, 32'(bus.out), 32'(eo));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    endtask

    task automatic apply(input logic r, input logic ce,
                         input logic [LAT_W-1:0] lat, input logic iv,
                         input logic [WIDTH-1:0] din);
        rst          = r;
        bus.ce       = ce;
        bus.lat      = lat;
        bus.in_valid = iv;
        bus.in       = din;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    initial begin
        // reset, then stream at latency 3
        vt[0]  = '{1, 0, 3, 0, 0,       0,       0, 0};
        vt[1]  = '{1, 1, 3, 0, 0,       0,       0, 0};
        vt[2]  = '{0, 1, 3, 1, 1,       0,       0, 0};
        vt[3]  = '{0, 1, 3, 1, 2,       0,       0, 0};
        vt[4]  = '{0, 1, 3, 1, 3,       1,       1, 0};
        vt[5]  = '{0, 1, 3, 1, 4,       2,       1, 0};
        // bypass
        vt[6]  = '{0, 1, 0, 1, 'h2AAAA, 'h2AAAA, 1, 0};
        vt[7]  = '{0, 1, 0, 0, 'h15555, 'h15555, 0, 0};
        // 0 -> 3 while data in flight
        vt[8]  = '{0, 1, 3, 1, 7,       'h2AAAA, 0, 1};
        vt[9]  = '{0, 1, 3, 1, 8,       'h15555, 0, 1};
        vt[10] = '{0, 1, 3, 1, 9,       7,       1, 0};
        // decrease 3 -> 1
        vt[11] = '{0, 1, 1, 1, 10,      10,      1, 0};
        vt[12] = '{0, 1, 1, 1, 11,      11,      1, 0};
        // increase 1 -> 3
        vt[13] = '{0, 1, 3, 1, 20,      10,      0, 1};
        vt[14] = '{0, 1, 3, 1, 21,      11,      0, 1};
        vt[15] = '{0, 1, 3, 1, 22,      20,      1, 0};
        vt[16] = '{0, 1, 3, 1, 23,      21,      1, 0};
        // ce gap with lat toggled, change taken on first ce edge
        vt[17] = '{0, 0, 2, 1, 99,      21,      1, 0};
        vt[18] = '{0, 0, 2, 1, 100,     21,      1, 0};
        vt[19] = '{0, 0, 3, 0, 101,     21,      1, 0};
        vt[20] = '{0, 0, 2, 1, 102,     21,      1, 0};
        vt[21] = '{0, 1, 2, 1, 30,      23,      0, 1};
        vt[22] = '{0, 1, 2, 1, 31,      30,      1, 0};
        // reset while settling beats a simultaneous lat change
        vt[23] = '{0, 1, 3, 1, 32,      30,      0, 1};
        vt[24] = '{1, 1, 0, 1, 33,      0,       0, 0};
        vt[25] = '{0, 1, 3, 1, 34,      0,       0, 0};

        for (int k = 0; k < DEPTH; k++) begin
            h_d[k] = '0;
            h_v[k] = 1'b0;
            h_i[k] = -1;
        end

        for (int i = 0; i < NVEC; i++) begin
            apply(vt[i].r, vt[i].ce, vt[i].lat, vt[i].iv, vt[i].din);
            step($sformatf("model[%0d]", i));
            check($sformatf("tbl[%0d].out", i),
                  32'(bus.out), 32'(vt[i].eout));
            check($sformatf("tbl[%0d].out_valid", i),
                  32'(bus.out_valid), 32'(vt[i].ev));
            check($sformatf("tbl[%0d].busy", i),
                  32'(bus.busy), 32'(vt[i].eb));
        end

        begin
            logic [LAT_W-1:0] rl;
            rl = 2'd3;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 5) == 0) rl = LAT_W'($urandom_range(0, 3));
                apply($urandom_range(0, 39) == 0,
                      $urandom_range(0, 3) != 0,
                      rl,
                      1'($urandom_range(0, 1)),
                      WIDTH'($urandom));
                step($sformatf("rnd[%0d]", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
